// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and defaults for the FIFO write arbiter
// Purpose: arbiter state encoding and the default byte width.
// Ports: none (package).
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin winner selection
// Purpose: returns the first set request bit scanning last+1, last+2, ...
//   modulo NUM_REQ (NUM_REQ need not be a power of two).
// Ports:
//   req     in   NUM_REQ  request vector
//   last    in   IDX_W    index granted most recently (lowest priority now)
//   winner  out  IDX_W    selected index, 0 when no request
//   valid   out  1        at least one request present
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    // Offset NUM_REQ wraps back to 'last' itself, so a lone requester that
    // just finished a burst can be granted again.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin bounded-burst arbiter for a FIFO write port
// Purpose: shares one byte FIFO write port among NUM_REQ producers; a winner
//   owns the port for up to MAX_BURST bytes, with one arbitration cycle
//   between bursts. No data is stored here.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   io_req          per-requester byte-present flags
//   io_data         requester i byte at [i*DATA_W +: DATA_W]
//   io_ack          one-hot, byte of the acked requester written this cycle
//   io_fifoWrite    FIFO write strobe
//   io_fifoDataIn   FIFO write data
//   io_fifoFull     FIFO full flag
//   io_busy         high while a burst is in progress
//   io_owner        current or last owner index
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4,
  parameter int IDX_W     = $clog2(NUM_REQ),
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        io_req,
  input  logic [NUM_REQ*DATA_W-1:0] io_data,
  output logic [NUM_REQ-1:0]        io_ack,
  output logic                      io_fifoWrite,
  output logic [DATA_W-1:0]         io_fifoDataIn,
  input  logic                      io_fifoFull,
  output logic                      io_busy,
  output logic [IDX_W-1:0]          io_owner
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] pick_winner;
  logic             pick_valid;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (io_req),
    .last   (last_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    count_d       = count_q;
    io_fifoWrite  = 1'b0;
    io_ack        = '0;
    io_fifoDataIn = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_winner;
          count_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        // Gating with reset keeps a mid-burst reset from writing a byte.
        io_fifoDataIn   = reset ? '0 : io_data[int'(owner_q)*DATA_W +: DATA_W];
        io_fifoWrite    = io_req[owner_q] & ~io_fifoFull & ~reset;
        io_ack[owner_q] = io_fifoWrite;
        if (!io_req[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (io_fifoWrite) begin
          count_d = count_q + 1'b1;
          if (count_q == CNT_W'(MAX_BURST - 1)) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign io_busy  = (state_q == BURST) & ~reset;
  assign io_owner = reset ? '0 : owner_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter
// Purpose: directed scenarios plus a randomized scoreboard run.
// Ports: none (top-level bench).
module tb_fifo_write_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  io_req;
  logic [31:0] io_data;
  logic [3:0]  io_ack;
  logic        io_fifoWrite;
  logic [7:0]  io_fifoDataIn;
  logic        io_fifoFull;
  logic        io_busy;
  logic [1:0]  io_owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .io_req        (io_req),
    .io_data       (io_data),
    .io_ack        (io_ack),
    .io_fifoWrite  (io_fifoWrite),
    .io_fifoDataIn (io_fifoDataIn),
    .io_fifoFull   (io_fifoFull),
    .io_busy       (io_busy),
    .io_owner      (io_owner)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    io_req      = '0;
    io_fifoFull = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    io_req      = 4'b1111;
    io_fifoFull = 1'b0;
    io_data     = 32'hDDCCBBAA;
    cyc();
    cyc();
    #1;
    checks++;
    if (io_fifoWrite !== 1'b0 || io_ack !== 4'b0 || io_busy !== 1'b0 ||
        io_owner !== 2'd0 || io_fifoDataIn !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: write=%b ack=%b busy=%b owner=%0d data=%h, expected all 0",
               io_fifoWrite, io_ack, io_busy, io_owner, io_fifoDataIn);
    end
    reset  = 1'b0;
    io_req = '0;
    cyc();
  endtask

  task automatic test_single();
    logic [7:0] eb;
    do_reset();
    io_req       = 4'b0001;
    io_data[7:0] = 8'hA0;
    #1;
    checks++;
    if (io_busy !== 1'b0 || io_fifoWrite !== 1'b0 || io_ack !== 4'b0) begin
      errors++;
      $display("FAIL single_arb: busy=%b write=%b ack=%b, expected 0 0 0000", io_busy, io_fifoWrite, io_ack);
    end
    cyc();
    for (int k = 0; k < 4; k++) begin
      eb           = 8'hA0 + 8'(k);
      io_data[7:0] = eb;
      #1;
      checks++;
      if (io_fifoWrite !== 1'b1 || io_ack !== 4'b0001 || io_fifoDataIn !== eb ||
          io_owner !== 2'd0 || io_busy !== 1'b1) begin
        errors++;
        $display("FAIL single_beat%0d: write=%b ack=%b data=%h owner=%0d busy=%b, expected 1 0001 %h 0 1",
                 k, io_fifoWrite, io_ack, io_fifoDataIn, io_owner, io_busy, eb);
      end
      cyc();
    end
    io_req = '0;
    #1;
    checks++;
    if (io_busy !== 1'b0 || io_fifoWrite !== 1'b0) begin
      errors++;
      $display("FAIL single_end_idle: busy=%b write=%b, expected 0 0", io_busy, io_fifoWrite);
    end
    cyc();
  endtask

  task automatic test_round_robin();
    int         order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] ea;
    logic [7:0] eb;
    do_reset();
    io_req  = 4'b1111;
    io_data = 32'h44332211;
    for (int g = 0; g < 5; g++) begin
      #1;
      checks++;
      if (io_busy !== 1'b0 || io_fifoWrite !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d: busy=%b write=%b, expected 0 0", g, io_busy, io_fifoWrite);
      end
      cyc();
      ea = 4'b0001 << order[g];
      eb = 8'h11 * 8'(order[g] + 1);
      for (int k = 0; k < 4; k++) begin
        #1;
        checks++;
        if (io_fifoWrite !== 1'b1 || io_ack !== ea || io_owner !== 2'(order[g]) ||
            io_fifoDataIn !== eb) begin
          errors++;
          $display("FAIL rr_grant%0d_beat%0d: write=%b ack=%b owner=%0d data=%h, expected 1 %b %0d %h",
                   g, k, io_fifoWrite, io_ack, io_owner, io_fifoDataIn, ea, order[g], eb);
        end
        cyc();
      end
    end
    io_req = '0;
    cyc();
  endtask

  task automatic test_full_stall();
    logic [7:0] eb;
    do_reset();
    io_req = 4'b0100;
    cyc();
    for (int k = 0; k < 7; k++) begin
      io_fifoFull = (k >= 2 && k < 5);
      eb          = 8'h20 + 8'(k < 2 ? k : (k < 5 ? 2 : k - 3));
      io_data[23:16] = eb;
      #1;
      checks++;
      if (io_fifoFull) begin
        if (io_fifoWrite !== 1'b0 || io_ack !== 4'b0 || io_owner !== 2'd2 || io_busy !== 1'b1) begin
          errors++;
          $display("FAIL stall_cycle%0d: write=%b ack=%b owner=%0d busy=%b, expected 0 0000 2 1",
                   k, io_fifoWrite, io_ack, io_owner, io_busy);
        end
      end else if (io_fifoWrite !== 1'b1 || io_ack !== 4'b0100 || io_fifoDataIn !== eb) begin
        errors++;
        $display("FAIL stall_write%0d: write=%b ack=%b data=%h, expected 1 0100 %h",
                 k, io_fifoWrite, io_ack, io_fifoDataIn, eb);
      end
      cyc();
    end
    io_fifoFull = 1'b0;
    #1;
    checks++;
    if (io_busy !== 1'b0 || io_fifoWrite !== 1'b0) begin
      errors++;
      $display("FAIL stall_count_held: busy=%b write=%b, expected 0 0 after 4 bytes", io_busy, io_fifoWrite);
    end
    io_req = '0;
    cyc();
  endtask

  task automatic test_drop();
    do_reset();
    io_req  = 4'b0010;
    io_data = 32'h30201050;
    cyc();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (io_ack !== 4'b0010 || io_owner !== 2'd1) begin
        errors++;
        $display("FAIL drop_beat%0d: ack=%b owner=%0d, expected 0010 1", k, io_ack, io_owner);
      end
      cyc();
    end
    io_req = 4'b1001;
    #1;
    checks++;
    if (io_fifoWrite !== 1'b0 || io_ack !== 4'b0 || io_busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_exit: write=%b ack=%b busy=%b, expected 0 0000 1", io_fifoWrite, io_ack, io_busy);
    end
    cyc();
    #1;
    checks++;
    if (io_busy !== 1'b0 || io_owner !== 2'd1) begin
      errors++;
      $display("FAIL drop_idle: busy=%b owner=%0d, expected 0 1", io_busy, io_owner);
    end
    cyc();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (io_ack !== 4'b1000 || io_owner !== 2'd3 || io_fifoDataIn !== 8'h30) begin
        errors++;
        $display("FAIL drop_next3_beat%0d: ack=%b owner=%0d data=%h, expected 1000 3 30",
                 k, io_ack, io_owner, io_fifoDataIn);
      end
      cyc();
    end
    cyc();
    #1;
    checks++;
    if (io_ack !== 4'b0001 || io_owner !== 2'd0) begin
      errors++;
      $display("FAIL drop_then0: ack=%b owner=%0d, expected 0001 0", io_ack, io_owner);
    end
    io_req = '0;
    cyc();
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    io_req  = 4'b0001;
    io_data = 32'h00000077;
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    checks++;
    if (io_fifoWrite !== 1'b0 || io_ack !== 4'b0 || io_busy !== 1'b0 ||
        io_owner !== 2'd0 || io_fifoDataIn !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs: write=%b ack=%b busy=%b owner=%0d data=%h, expected all 0",
               io_fifoWrite, io_ack, io_busy, io_owner, io_fifoDataIn);
    end
    cyc();
    reset  = 1'b0;
    io_req = 4'b1111;
    #1;
    checks++;
    if (io_busy !== 1'b0 || io_fifoWrite !== 1'b0 || io_owner !== 2'd0) begin
      errors++;
      $display("FAIL midreset_idle: busy=%b write=%b owner=%0d, expected 0 0 0", io_busy, io_fifoWrite, io_owner);
    end
    cyc();
    #1;
    checks++;
    if (io_ack !== 4'b0001 || io_owner !== 2'd0) begin
      errors++;
      $display("FAIL midreset_first_grant: ack=%b owner=%0d, expected 0001 0", io_ack, io_owner);
    end
    io_req = '0;
    cyc();
    cyc();
  endtask

  task automatic test_random();
    logic [5:0] seq [4];
    logic [3:0] req_m;
    logic [3:0] req_prev;
    logic       busy_prev;
    int         others [4];
    int         beats;
    int         total;
    logic [1:0] idx;
    logic [7:0] eb;
    do_reset();
    req_m     = '0;
    req_prev  = '0;
    busy_prev = 1'b0;
    beats     = 0;
    total     = 0;
    for (int i = 0; i < 4; i++) begin
      seq[i]    = '0;
      others[i] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      io_req = req_m;
      for (int i = 0; i < 4; i++) io_data[i*8 +: 8] = {2'(i), seq[i]};
      io_fifoFull = ($urandom_range(0, 3) == 0);
      #1;
      checks++;
      if (io_fifoWrite && io_fifoFull) begin
        errors++;
        $display("FAIL rand_write_full cycle %0d: write=1 while full=1, expected write=0", c);
      end
      checks++;
      if (io_fifoWrite !== (|io_ack) || !$onehot0(io_ack)) begin
        errors++;
        $display("FAIL rand_ack cycle %0d: write=%b ack=%b, expected one-hot ack matching write", c, io_fifoWrite, io_ack);
      end
      if (io_busy && !busy_prev) begin
        beats = 0;
        for (int i = 0; i < 4; i++) begin
          if (io_owner == 2'(i)) others[i] = 0;
          else if (req_prev[i]) others[i]++;
          checks++;
          if (others[i] > NUM_REQ - 1) begin
            errors++;
            $display("FAIL rand_starve cycle %0d: requester %0d passed over %0d times, expected <= %0d",
                     c, i, others[i], NUM_REQ - 1);
          end
        end
      end
      if (io_ack != 4'b0) begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++) if (io_ack[i]) idx = 2'(i);
        eb = {idx, seq[idx]};
        beats++;
        checks++;
        if (!req_m[idx] || io_fifoDataIn !== eb || beats > MAX_BURST) begin
          errors++;
          $display("FAIL rand_order cycle %0d: req=%b data=%h beats=%0d, expected req set, data %h, beats <= %0d",
                   c, req_m, io_fifoDataIn, beats, eb, MAX_BURST);
        end
      end
      busy_prev = io_busy;
      req_prev  = req_m;
      for (int i = 0; i < 4; i++) begin
        if (io_ack[i]) begin
          seq[i]++;
          total++;
          req_m[i] = 1'($urandom_range(0, 1));
        end else if (req_m[i]) begin
          if ($urandom_range(0, 15) == 0) req_m[i] = 1'b0;
        end else begin
          req_m[i] = 1'($urandom_range(0, 1));
        end
        if (!req_m[i]) others[i] = 0;
      end
      cyc();
    end
    checks++;
    if (total < 1000) begin
      errors++;
      $display("FAIL rand_throughput: %0d bytes written, expected >= 1000", total);
    end
    io_req = '0;
    io_fifoFull = 1'b0;
    cyc();
  endtask

  initial begin
    reset       = 1'b1;
    io_req      = '0;
    io_data     = '0;
    io_fifoFull = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_drop();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
